raster_engine: RTL
==================

# raster_engine

Parametrised drawing engine that accepts packed draw instructions, decodes them and streams rasterised pixel coordinates. It is the successor to the single-primitive processor. Line (Bresenham), circle (midpoint, 8-way symmetric) and single-pixel primitives are all instantiated and selected per instruction by opcode, not fixed at build time. It sits between the instruction source and the pixel/framebuffer writer, with valid/ready handshakes on both sides.

## Interface
- X_W, 9, signed x coordinate width (x1, x2, radius, x_out)
- Y_W, 8, signed y coordinate width (y1, y2, y_out)
- INSTR_W, 3+2*(X_W+Y_W) (=37), instruction width; not independently settable
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instr  in  INSTR_W  packed instruction, MSB→LSB: opcode[2:0], x1, y1, x2, y2
- instr_valid  in  1  instr is valid
- instr_ready  out  1  engine idle, instr accepted on valid&&ready
- x_out  out  X_W  signed pixel x
- y_out  out  Y_W  signed pixel y
- pix_valid  out  1  x_out/y_out hold a pixel
- pix_ready  in  1  downstream accepts pixel on pix_valid&&pix_ready
- busy  out  1  instruction in progress
- done  out  1  one-cycle pulse, instruction complete
- err  out  1  one-cycle pulse coincident with done, instruction rejected

## Operation
- Opcodes: 000 NOP; 001 PIXEL (x1,y1); 010 LINE (x1,y1)→(x2,y2); 011 CIRCLE centre (x1,y1), radius x2; 1xx reserved.
- States: IDLE, PIXEL, LINE, CIRCLE, FINISH. IDLE→{PIXEL,LINE,CIRCLE} on accept; NOP, reserved opcodes and CIRCLE with r<0 go IDLE→FINISH. Last pixel handshake→FINISH; FINISH→IDLE after one cycle.
- Reserved opcodes and r<0 emit no pixels and pulse err with done.
- instr_ready = (state==IDLE). busy = !IDLE.
- LINE: integer Bresenham covering all octants, endpoints inclusive, order from (x1,y1) to (x2,y2).
  - Setup: dx=|x2-x1|, dy=|y2-y1|, sx/sy=±1, err=dx-dy.
  - Per pixel: emit (x,y); stop if (x,y)==(x2,y2); e2=2*err; if e2>-dy {err-=dy; x+=sx}; if e2<dx {err+=dx; y+=sy}.
  - Pixel count = max(dx,dy)+1. Internal err/delta width ≥ X_W+2.
- CIRCLE: midpoint algorithm.
  - Setup: x=0, y=r, d=1-r.
  - Per iteration while x<=y: emit 8 points in this order: (xc+x,yc+y), (xc+y,yc+x), (xc-x,yc+y), (xc-y,yc+x), (xc+x,yc-y), (xc+y,yc-x), (xc-x,yc-y), (xc-y,yc-x).
  - Then x++; if d<0 then d+=2x+1, else {y--; d+=2(x-y)+1} (using the new x).
  - Duplicates are emitted, never suppressed; 8 points per iteration always. r=0 emits 8 copies of the centre.
- Output coordinates are computed at full internal width and truncated to X_W/Y_W (two's-complement wrap); no clipping.

## Timing
- Reset (async assert, sync-safe release): state=IDLE; instr_ready=1; pix_valid=0; busy=0; done=0; err=0; x_out=0; y_out=0.
- Reset mid-instruction aborts immediately. Partial primitives are dropped, and no done is issued.
- First pixel: pix_valid rises the cycle after instruction accept (registered setup; 1-cycle latency).
- With pix_ready held high, throughput is one pixel per clock with no bubbles, including between circle iterations. The iteration update occurs on the 8th point's handshake.
- While pix_valid && !pix_ready, x_out/y_out/pix_valid hold stable and internal state freezes.
- done (and err where applicable) pulses in the cycle after the final pixel handshake, in FINISH. instr_ready rises the next cycle. NOP/reserved: done in cycle accept+1.
- instr is sampled only on accept; changes to instr while busy are ignored.

## Test plan
- Reset during a CIRCLE r=10 after 5 pixels:
  - pix_valid and busy drop asynchronously, and no done is issued.
  - A following PIXEL (1,1) executes normally.
- PIXEL (-3,7) with pix_ready=1:
  - Exactly one pixel (-3,7) in cycle accept+1.
  - done in cycle accept+2, err=0.
- LINE (0,0)→(3,1), pix_ready=1:
  - Pixels (0,0),(1,0),(2,1),(3,1) on consecutive cycles, then done.
  - The reversed line (3,1)→(0,0) yields (3,1),(2,1),(1,0),(0,0).
- CIRCLE centre (0,0), r=5:
  - 32 pixels. Iteration octant points are (0,5),(1,5),(2,5),(3,4).
  - The first 8 are (0,5),(5,0),(0,5),(-5,0),(0,-5),(5,0),(0,-5),(-5,0).
- Backpressure: LINE (0,0)→(0,4) with pix_ready toggling randomly.
  - Outputs are held stable while stalled.
  - The exact 5-pixel sequence (0,0)…(0,4) is seen with no loss or duplication.
- Opcode 101, then CIRCLE r=-1:
  - Each gives zero pixels with done+err in cycle accept+1.
  - instr_ready is high again in cycle accept+2.

Source files
------------

// File: rtl/raster_engine_if.sv
// Instruction-in / pixel-out handshake bundle for raster_engine.
// The engine side is the slave modport; the instruction source and pixel sink are the master.
interface raster_engine_if #(
    parameter int X_W = 9,
    parameter int Y_W = 8
);
    localparam int INSTR_W = 3 + 2 * (X_W + Y_W);

    logic [INSTR_W-1:0]    instr;
    logic                  instr_valid;
    logic                  instr_ready;
    logic signed [X_W-1:0] x_out;
    logic signed [Y_W-1:0] y_out;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output instr, instr_valid, pix_ready,
        input  instr_ready, x_out, y_out, pix_valid, busy, done, err
    );

    modport slave (
        input  instr, instr_valid, pix_ready,
        output instr_ready, x_out, y_out, pix_valid, busy, done, err
    );
endinterface

// File: rtl/raster_engine.sv
// Decodes packed draw instructions and streams pixels for PIXEL, Bresenham LINE
// and 8-way symmetric midpoint CIRCLE primitives, one pixel per accepted handshake.
module raster_engine #(
    parameter int X_W = 9,
    parameter int Y_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    raster_engine_if.slave  bus
);
    localparam int INSTR_W = 3 + 2 * (X_W + Y_W);
    localparam int IW      = ((X_W > Y_W) ? X_W : Y_W) + 4;
    localparam logic signed [IW-1:0] ONE = IW'(1);

    typedef enum logic [2:0] {S_IDLE, S_PIXEL, S_LINE, S_CIRCLE, S_FINISH} state_t;

    state_t                r_state;
    logic signed [IW-1:0]  r_px, r_py;
    logic                  r_pv, r_done, r_err;
    logic signed [IW-1:0]  r_ex, r_ey, r_dx, r_dy, r_lerr;
    logic                  r_sx_neg, r_sy_neg;
    logic signed [IW-1:0]  r_cx, r_cy, r_ox, r_oy, r_d;
    logic [2:0]            r_k;

    logic [2:0]            w_op;
    logic signed [IW-1:0]  w_x1, w_y1, w_x2, w_y2, w_dxr, w_dyr, w_dx, w_dy;
    logic signed [IW-1:0]  w_e2, w_lerr_n, w_lx_n, w_ly_n;
    logic signed [IW-1:0]  w_cox_n, w_coy_n, w_d_n, w_ox_sel, w_oy_sel, w_a, w_b, w_ptx, w_pty;
    logic                  w_stx, w_sty, w_circ_more, w_hs;
    logic [2:0]            w_k_n;

    assign w_op  = bus.instr[INSTR_W-1 -: 3];
    assign w_x1  = IW'($signed(bus.instr[2*Y_W+X_W +: X_W]));
    assign w_y1  = IW'($signed(bus.instr[Y_W+X_W   +: Y_W]));
    assign w_x2  = IW'($signed(bus.instr[Y_W       +: X_W]));
    assign w_y2  = IW'($signed(bus.instr[0         +: Y_W]));
    assign w_dxr = w_x2 - w_x1;
    assign w_dyr = w_y2 - w_y1;
    assign w_dx  = w_dxr[IW-1] ? -w_dxr : w_dxr;
    assign w_dy  = w_dyr[IW-1] ? -w_dyr : w_dyr;
    assign w_hs  = r_pv && bus.pix_ready;

    always_comb begin
        // Bresenham step from the current pixel
        w_e2     = r_lerr <<< 1;
        w_stx    = (w_e2 > -r_dy);
        w_sty    = (w_e2 < r_dx);
        w_lerr_n = r_lerr;
        w_lx_n   = r_px;
        w_ly_n   = r_py;
        if (w_stx) begin
            w_lerr_n = w_lerr_n - r_dy;
            w_lx_n   = r_sx_neg ? r_px - ONE : r_px + ONE;
        end
        if (w_sty) begin
            w_lerr_n = w_lerr_n + r_dx;
            w_ly_n   = r_sy_neg ? r_py - ONE : r_py + ONE;
        end

        // Midpoint iteration update, only committed after the 8th point
        w_cox_n = r_ox + ONE;
        if (r_d < 0) begin
            w_coy_n = r_oy;
            w_d_n   = r_d + (w_cox_n <<< 1) + ONE;
        end else begin
            w_coy_n = r_oy - ONE;
            w_d_n   = r_d + ((w_cox_n - w_coy_n) <<< 1) + ONE;
        end
        w_circ_more = (w_cox_n <= w_coy_n);

        if (r_k == 3'd7) begin
            w_k_n    = 3'd0;
            w_ox_sel = w_cox_n;
            w_oy_sel = w_coy_n;
        end else begin
            w_k_n    = r_k + 3'd1;
            w_ox_sel = r_ox;
            w_oy_sel = r_oy;
        end
        // k[0] swaps x/y, k[1] negates the x offset, k[2] negates the y offset
        w_a   = w_k_n[0] ? w_oy_sel : w_ox_sel;
        w_b   = w_k_n[0] ? w_ox_sel : w_oy_sel;
        w_ptx = w_k_n[1] ? r_cx - w_a : r_cx + w_a;
        w_pty = w_k_n[2] ? r_cy - w_b : r_cy + w_b;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_px     <= '0;
            r_py     <= '0;
            r_pv     <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ex     <= '0;
            r_ey     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_lerr   <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_d      <= '0;
            r_k      <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.instr_valid) begin
                    case (w_op)
                        3'b001: begin
                            r_px    <= w_x1;
                            r_py    <= w_y1;
                            r_pv    <= 1'b1;
                            r_state <= S_PIXEL;
                        end
                        3'b010: begin
                            r_px     <= w_x1;
                            r_py     <= w_y1;
                            r_ex     <= w_x2;
                            r_ey     <= w_y2;
                            r_dx     <= w_dx;
                            r_dy     <= w_dy;
                            r_lerr   <= w_dx - w_dy;
                            r_sx_neg <= w_dxr[IW-1];
                            r_sy_neg <= w_dyr[IW-1];
                            r_pv     <= 1'b1;
                            r_state  <= S_LINE;
                        end
                        3'b011: begin
                            if (w_x2[IW-1]) begin
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                                r_state <= S_FINISH;
                            end else begin
                                r_cx    <= w_x1;
                                r_cy    <= w_y1;
                                r_ox    <= '0;
                                r_oy    <= w_x2;
                                r_d     <= ONE - w_x2;
                                r_k     <= 3'd0;
                                r_px    <= w_x1;
                                r_py    <= w_y1 + w_x2;
                                r_pv    <= 1'b1;
                                r_state <= S_CIRCLE;
                            end
                        end
                        3'b000: begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end
                        default: begin
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    endcase
                end
                S_PIXEL: if (w_hs) begin
                    r_pv    <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_FINISH;
                end
                S_LINE: if (w_hs) begin
                    if (r_px == r_ex && r_py == r_ey) begin
                        r_pv    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_px   <= w_lx_n;
                        r_py   <= w_ly_n;
                        r_lerr <= w_lerr_n;
                    end
                end
                S_CIRCLE: if (w_hs) begin
                    if (r_k == 3'd7 && !w_circ_more) begin
                        r_pv    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        if (r_k == 3'd7) begin
                            r_ox <= w_cox_n;
                            r_oy <= w_coy_n;
                            r_d  <= w_d_n;
                        end
                        r_k  <= w_k_n;
                        r_px <= w_ptx;
                        r_py <= w_pty;
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.x_out       = r_px[X_W-1:0];
    assign bus.y_out       = r_py[Y_W-1:0];
    assign bus.pix_valid   = r_pv;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
endmodule
